// File: rtl/symbol_reorder_if.sv
// Symbol stream bundle between the RMII dibit receiver and the reorder block.
interface symbol_reorder_if #(
    parameter int SYM_W = 2
);
    logic             axiiv;
    logic [SYM_W-1:0] axiid;
    logic             reverse;
    logic             axiov;
    logic [SYM_W-1:0] axiod;
    logic             axiolast;
    logic             trunc;

    modport master (
        output axiiv, axiid, reverse,
        input  axiov, axiod, axiolast, trunc
    );

    modport slave (
        input  axiiv, axiid, reverse,
        output axiov, axiod, axiolast, trunc
    );
endinterface

// File: rtl/symbol_reorder.sv
// Streaming symbol-order converter: collects SYMS_PER_WORD symbols into one
// half of a ping-pong buffer while the other half drains one symbol per cycle,
// either reversed or in arrival order.
//
// state    | meaning
// ST_IDLE  | no completed word pending, outputs held at zero
// ST_DRAIN | emitting symbol j_q of the word in half dbuf_q
module symbol_reorder #(
    parameter int SYM_W         = 2,
    parameter int SYMS_PER_WORD = 4
) (
    input logic             clk,
    input logic             rst,
    symbol_reorder_if.slave bus
);
    localparam int            CW   = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SYMS_PER_WORD - 1);

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    j_q, j_d;
    logic             sel_q, sel_d;
    logic             dbuf_q, dbuf_d;
    logic             dmode_q, dmode_d;
    logic             fmode_q, fmode_d;
    logic             prev_v_q, prev_v_d;
    logic             axiov_q, axiov_d;
    logic [SYM_W-1:0] axiod_q, axiod_d;
    logic             axiolast_q, axiolast_d;
    logic             trunc_q, trunc_d;

    logic [SYM_W-1:0] slot_q [2][SYMS_PER_WORD];

    logic             first_sym;
    logic             frame_end;
    logic             word_done;
    logic             mode_eff;
    logic [CW-1:0]    rd_idx;

    // Next-state for fill counter, ping-pong select, drain sequencer and outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        j_d        = j_q;
        sel_d      = sel_q;
        dbuf_d     = dbuf_q;
        dmode_d    = dmode_q;
        fmode_d    = fmode_q;
        prev_v_d   = bus.axiiv;
        axiov_d    = 1'b0;
        axiod_d    = '0;
        axiolast_d = 1'b0;
        trunc_d    = 1'b0;

        first_sym = bus.axiiv && !prev_v_q;
        frame_end = !bus.axiiv && prev_v_q;
        word_done = bus.axiiv && (cnt_q == LAST);
        // The first symbol of a frame uses reverse directly; later symbols use the latched copy.
        mode_eff  = first_sym ? bus.reverse : fmode_q;
        rd_idx    = dmode_q ? (LAST - j_q) : j_q;

        if (first_sym) begin
            fmode_d = bus.reverse;
        end

        if (bus.axiiv) begin
            if (word_done) begin
                cnt_d = '0;
                sel_d = ~sel_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A partial word is dropped; its half of the buffer is simply reused.
        if (frame_end) begin
            cnt_d   = '0;
            trunc_d = (cnt_q != '0);
        end

        if (state_q == ST_DRAIN) begin
            axiov_d = 1'b1;
            axiod_d = slot_q[dbuf_q][rd_idx];
            if (j_q == LAST) begin
                axiolast_d = !word_done;
                state_d    = ST_IDLE;
            end else begin
                j_d = j_q + CW'(1);
            end
        end

        // A word completing on the final drain edge restarts the drain seamlessly.
        if (word_done) begin
            state_d = ST_DRAIN;
            j_d     = '0;
            dbuf_d  = sel_q;
            dmode_d = mode_eff;
        end
    end

    // Control and output registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            j_q        <= '0;
            sel_q      <= 1'b0;
            dbuf_q     <= 1'b0;
            dmode_q    <= 1'b0;
            fmode_q    <= 1'b0;
            prev_v_q   <= 1'b0;
            axiov_q    <= 1'b0;
            axiod_q    <= '0;
            axiolast_q <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            j_q        <= j_d;
            sel_q      <= sel_d;
            dbuf_q     <= dbuf_d;
            dmode_q    <= dmode_d;
            fmode_q    <= fmode_d;
            prev_v_q   <= prev_v_d;
            axiov_q    <= axiov_d;
            axiod_q    <= axiod_d;
            axiolast_q <= axiolast_d;
            trunc_q    <= trunc_d;
        end
    end

    // Symbol storage needs no reset; it is only read after a full word is written.
    always_ff @(posedge clk) begin
        if (bus.axiiv) begin
            slot_q[sel_q][cnt_q] <= bus.axiid;
        end
    end

    assign bus.axiov    = axiov_q;
    assign bus.axiod    = axiod_q;
    assign bus.axiolast = axiolast_q;
    assign bus.trunc    = trunc_q;
endmodule

// File: tb/tb_symbol_reorder.sv
// Directed bench for symbol_reorder: a 2-bit/4-symbol instance and a
// 4-bit/2-symbol instance on a shared clock and reset.
module tb_symbol_reorder;
    logic clk;
    logic rst;
    logic use2;
    int   vectors;
    int   miscompares;

    symbol_reorder_if #(.SYM_W(2)) u1 ();
    symbol_reorder_if #(.SYM_W(4)) u2 ();

    symbol_reorder #(.SYM_W(2), .SYMS_PER_WORD(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u1)
    );

    symbol_reorder #(.SYM_W(4), .SYMS_PER_WORD(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (u2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {axiov, axiod (zero-extended to 4 bits), axiolast, trunc}.
    task automatic check(input logic [6:0] exp, input string tag);
        logic [6:0] obs;
        if (use2) obs = {u2.axiov, u2.axiod, u2.axiolast, u2.trunc};
        else      obs = {u1.axiov, 2'b00, u1.axiod, u1.axiolast, u1.trunc};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed v/d/last/trunc=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] d, input logic rev,
                       input logic ev, input logic [3:0] ed, input logic el,
                       input logic et, input string tag);
        if (use2) begin
            u2.axiiv = v; u2.axiid = d; u2.reverse = rev;
        end else begin
            u1.axiiv = v; u1.axiid = d[1:0]; u1.reverse = rev;
        end
        @(posedge clk);
        #1;
        check({ev, ed, el, et}, tag);
    endtask

    // One byte 0xB4 (dibits 0,1,3,2) in reverse mode -> 2,3,1,0.
    task automatic byte_b4_rev(input string p);
        cyc(1, 0, 1, 0, 0, 0, 0, {p, "_e0"});
        cyc(1, 1, 1, 0, 0, 0, 0, {p, "_e1"});
        cyc(1, 3, 1, 0, 0, 0, 0, {p, "_e2"});
        cyc(1, 2, 1, 0, 0, 0, 0, {p, "_e3"});
        cyc(0, 0, 1, 1, 2, 0, 0, {p, "_o0"});
        cyc(0, 0, 1, 1, 3, 0, 0, {p, "_o1"});
        cyc(0, 0, 1, 1, 1, 0, 0, {p, "_o2"});
        cyc(0, 0, 1, 1, 0, 1, 0, {p, "_o3"});
        cyc(0, 0, 1, 0, 0, 0, 0, {p, "_idle"});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        use2        = 1'b0;
        u1.axiiv = 1'b0; u1.axiid = '0; u1.reverse = 1'b0;
        u2.axiiv = 1'b0; u2.axiid = '0; u2.reverse = 1'b0;
        rst = 1'b1;
        #2;
        check(7'b0, "reset_async");
        @(posedge clk);
        #1;
        check(7'b0, "reset_held");
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, "idle0");

        // Scenario 1: reverse mode single byte
        byte_b4_rev("s1");

        // Scenario 2: pass mode single byte -> 0,1,3,2
        cyc(1, 0, 0, 0, 0, 0, 0, "s2_e0");
        cyc(1, 1, 0, 0, 0, 0, 0, "s2_e1");
        cyc(1, 3, 0, 0, 0, 0, 0, "s2_e2");
        cyc(1, 2, 0, 0, 0, 0, 0, "s2_e3");
        cyc(0, 0, 0, 1, 0, 0, 0, "s2_o0");
        cyc(0, 0, 0, 1, 1, 0, 0, "s2_o1");
        cyc(0, 0, 0, 1, 3, 0, 0, "s2_o2");
        cyc(0, 0, 0, 1, 2, 1, 0, "s2_o3");
        cyc(0, 0, 0, 0, 0, 0, 0, "s2_idle");

        // Scenario 3: 0x55,0xB4,0x0F reverse -> 1,1,1,1 2,3,1,0 0,0,3,3
        cyc(1, 1, 1, 0, 0, 0, 0, "s3_e0");
        cyc(1, 1, 1, 0, 0, 0, 0, "s3_e1");
        cyc(1, 1, 1, 0, 0, 0, 0, "s3_e2");
        cyc(1, 1, 1, 0, 0, 0, 0, "s3_e3");
        cyc(1, 0, 1, 1, 1, 0, 0, "s3_e4");
        cyc(1, 1, 1, 1, 1, 0, 0, "s3_e5");
        cyc(1, 3, 1, 1, 1, 0, 0, "s3_e6");
        cyc(1, 2, 1, 1, 1, 0, 0, "s3_e7");
        cyc(1, 3, 1, 1, 2, 0, 0, "s3_e8");
        cyc(1, 3, 1, 1, 3, 0, 0, "s3_e9");
        cyc(1, 0, 1, 1, 1, 0, 0, "s3_e10");
        cyc(1, 0, 1, 1, 0, 0, 0, "s3_e11");
        cyc(0, 0, 1, 1, 0, 0, 0, "s3_e12");
        cyc(0, 0, 1, 1, 0, 0, 0, "s3_e13");
        cyc(0, 0, 1, 1, 3, 0, 0, "s3_e14");
        cyc(0, 0, 1, 1, 3, 1, 0, "s3_e15");
        cyc(0, 0, 1, 0, 0, 0, 0, "s3_idle");

        // Scenario 4: byte 0xB4 + two extra dibits, reverse; trunc at frame end
        cyc(1, 0, 1, 0, 0, 0, 0, "s4_e0");
        cyc(1, 1, 1, 0, 0, 0, 0, "s4_e1");
        cyc(1, 3, 1, 0, 0, 0, 0, "s4_e2");
        cyc(1, 2, 1, 0, 0, 0, 0, "s4_e3");
        cyc(1, 1, 1, 1, 2, 0, 0, "s4_e4");
        cyc(1, 1, 1, 1, 3, 0, 0, "s4_e5");
        cyc(0, 0, 1, 1, 1, 0, 1, "s4_e6");
        cyc(0, 0, 1, 1, 0, 1, 0, "s4_e7");
        cyc(0, 0, 1, 0, 0, 0, 0, "s4_e8");
        cyc(0, 0, 1, 0, 0, 0, 0, "s4_e9");

        // Scenario 5: pass 0xB4 (reverse raised mid-frame, ignored), gap, reverse 0x2D
        cyc(1, 0, 0, 0, 0, 0, 0, "s5_e0");
        cyc(1, 1, 1, 0, 0, 0, 0, "s5_e1");
        cyc(1, 3, 1, 0, 0, 0, 0, "s5_e2");
        cyc(1, 2, 1, 0, 0, 0, 0, "s5_e3");
        cyc(0, 0, 1, 1, 0, 0, 0, "s5_e4");
        cyc(1, 1, 1, 1, 1, 0, 0, "s5_e5");
        cyc(1, 3, 1, 1, 3, 0, 0, "s5_e6");
        cyc(1, 2, 1, 1, 2, 1, 0, "s5_e7");
        cyc(1, 0, 1, 0, 0, 0, 0, "s5_e8");
        cyc(0, 0, 1, 1, 0, 0, 0, "s5_e9");
        cyc(0, 0, 1, 1, 2, 0, 0, "s5_e10");
        cyc(0, 0, 1, 1, 3, 0, 0, "s5_e11");
        cyc(0, 0, 1, 1, 1, 1, 0, "s5_e12");
        cyc(0, 0, 1, 0, 0, 0, 0, "s5_idle");

        // Scenario 6: asynchronous reset mid-drain, then a clean byte
        cyc(1, 0, 1, 0, 0, 0, 0, "s6_e0");
        cyc(1, 1, 1, 0, 0, 0, 0, "s6_e1");
        cyc(1, 3, 1, 0, 0, 0, 0, "s6_e2");
        cyc(1, 2, 1, 0, 0, 0, 0, "s6_e3");
        cyc(0, 0, 1, 1, 2, 0, 0, "s6_o0");
        cyc(0, 0, 1, 1, 3, 0, 0, "s6_o1");
        #2;
        rst = 1'b1;
        #1;
        check(7'b0, "s6_rst_async");
        @(posedge clk);
        #1;
        check(7'b0, "s6_rst_held");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check(7'b0, "s6_post0");
        cyc(0, 0, 1, 0, 0, 0, 0, "s6_post1");
        cyc(0, 0, 1, 0, 0, 0, 0, "s6_post2");
        byte_b4_rev("s6b");

        // Scenario 7: SYM_W=4, N=2: byte 0xB4 as nibbles 4,B reversed -> B,4
        use2 = 1'b1;
        cyc(0, 0, 1, 0, 0, 0, 0, "s7_idle0");
        cyc(1, 4'h4, 1, 0, 4'h0, 0, 0, "s7_e0");
        cyc(1, 4'hB, 1, 0, 4'h0, 0, 0, "s7_e1");
        cyc(0, 0, 1, 1, 4'hB, 0, 0, "s7_o0");
        cyc(0, 0, 1, 1, 4'h4, 1, 0, "s7_o1");
        cyc(0, 0, 1, 0, 4'h0, 0, 0, "s7_idle1");
        // Frame shorter than one word: trunc only, no output
        cyc(1, 4'h7, 1, 0, 4'h0, 0, 0, "s7_short_e0");
        cyc(0, 0, 1, 0, 4'h0, 0, 1, "s7_short_end");
        cyc(0, 0, 1, 0, 4'h0, 0, 0, "s7_short_idle0");
        cyc(0, 0, 1, 0, 4'h0, 0, 0, "s7_short_idle1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
